// File: rtl/int_ctrl.sv
// Purpose: 8-line interrupt controller with edge/level modes, mask, pending and priority vector.
// Latency: INT edge to Interrupts is SYNC_STAGES+2 clk; register reads return one clk after the address.
// Backpressure: none; CPU accesses complete in one cycle and Interrupts is a registered level.
module int_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  INT,
   input  logic        CS,
   input  logic        write,
   input  logic [1:0]  adresse,
   input  logic [15:0] DATAout,
   output logic [15:0] DATAin,
   output logic [7:0]  Interrupts
);

   localparam logic [1:0] ADR_PEND   = 2'd0;
   localparam logic [1:0] ADR_MASK   = 2'd1;
   localparam logic [1:0] ADR_MODE   = 2'd2;
   localparam logic [1:0] ADR_VECTOR = 2'd3;

   logic [7:0]  sync_q [SYNC_STAGES];
   logic [7:0]  s;
   logic [7:0]  prev;
   logic [7:0]  pend;
   logic [7:0]  mask;
   logic [7:0]  mode;

   logic [7:0]  act;
   logic [7:0]  edge_det;
   logic [7:0]  clr;
   logic [7:0]  pend_nxt;
   logic [7:0]  onehot;
   logic [2:0]  win;
   logic [15:0] rd_mux;
   logic        wr_en;
   logic        rd_en;

   // The upper byte of write data has no destination register.
   logic        dout_hi_unused;
   assign dout_hi_unused = ^DATAout[15:8];

   assign s        = sync_q[SYNC_STAGES-1];
   assign act      = pend & mask;
   assign edge_det = s & ~prev;
   assign wr_en    = CS & write;
   assign rd_en    = CS & ~write;
   assign clr      = (wr_en && adresse == ADR_PEND) ? DATAout[7:0] : 8'h00;

   // Edge-mode bits: a new edge wins over a same-cycle clear; level-mode bits follow s.
   assign pend_nxt = (mode & (edge_det | (pend & ~clr))) | (~mode & s);

   // Lowest-index active request wins; scanning downward leaves the lowest one last.
   always_comb begin
      win    = 3'd0;
      onehot = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         if (act[i]) begin
            win    = 3'(i);
            onehot = 8'h01 << i;
         end
      end
   end

   // Read data selection for the register addressed this cycle.
   always_comb begin
      rd_mux = 16'h0000;
      case (adresse)
         ADR_PEND:   rd_mux = {8'h00, pend};
         ADR_MASK:   rd_mux = {8'h00, mask};
         ADR_MODE:   rd_mux = {8'h00, mode};
         ADR_VECTOR: rd_mux = {|act, 12'h000, win};
         default:    rd_mux = 16'h0000;
      endcase
   end

   // Input synchronisers and the one-clk delayed copy used for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 8'h00;
         prev <= 8'h00;
      end else begin
         sync_q[0] <= INT;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         prev <= s;
      end
   end

   // Register file: pending capture plus CPU writes to MASK and MODE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= 8'h00;
         mask <= 8'h00;
         mode <= 8'hFF;
      end else begin
         pend <= pend_nxt;
         if (wr_en && adresse == ADR_MASK) mask <= DATAout[7:0];
         if (wr_en && adresse == ADR_MODE) mode <= DATAout[7:0];
      end
   end

   // Registered outputs: one-hot request and read data held between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Interrupts <= 8'h00;
         DATAin     <= 16'h0000;
      end else begin
         Interrupts <= onehot;
         if (rd_en) DATAin <= rd_mux;
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Purpose: randomized and directed checking of int_ctrl against a queue-based reference model.
// Latency: model advances once per rising edge and is compared 1 time unit later.
// Backpressure: not applicable; the bench drives the bus every cycle.
module tb_int_ctrl;

   localparam int SS = 2;

   logic        clk;
   logic        rst;
   logic [7:0]  int_l;
   logic        cs;
   logic        wr;
   logic [1:0]  adr;
   logic [15:0] dout;
   logic [15:0] dat_in;
   logic [7:0]  intr;

   int n_cmp;
   int n_err;

   int_ctrl #(.SYNC_STAGES(SS)) dut (
      .clk        (clk),
      .rst        (rst),
      .INT        (int_l),
      .CS         (cs),
      .write      (wr),
      .adresse    (adr),
      .DATAout    (dout),
      .DATAin     (dat_in),
      .Interrupts (intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: INT samples per edge, newest first.
   logic [7:0]  m_hist [$];
   logic [7:0]  m_s, m_prev, m_pend, m_mask, m_mode, m_intr;
   logic [15:0] m_dat;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist = {};
      for (int k = 0; k < SS; k++) m_hist.push_front(8'h00);
      m_s = 8'h00; m_prev = 8'h00;
      m_pend = 8'h00; m_mask = 8'h00; m_mode = 8'hFF;
      m_intr = 8'h00; m_dat = 16'h0000;
   endtask

   // Everything on the right-hand side is the pre-edge state.
   task automatic model_step();
      logic [7:0]  act, clr, edges, npend, low;
      logic [15:0] vec;
      int          idx;
      act = m_pend & m_mask;
      low = act & (~act + 8'h01);
      idx = 0;
      for (int b = 0; b < 8; b++) if (low == (8'h01 << b)) idx = b;
      vec = (act != 0) ? (16'h8000 | 16'(idx)) : 16'h0000;
      edges = m_s & ~m_prev;
      clr = (cs && wr && adr == 2'd0) ? dout[7:0] : 8'h00;
      npend = 8'h00;
      for (int b = 0; b < 8; b++) begin
         if (m_mode[b]) npend[b] = edges[b] | (m_pend[b] & ~clr[b]);
         else           npend[b] = m_s[b];
      end
      if (cs && !wr) begin
         case (adr)
            2'd0: m_dat = {8'h00, m_pend};
            2'd1: m_dat = {8'h00, m_mask};
            2'd2: m_dat = {8'h00, m_mode};
            default: m_dat = vec;
         endcase
      end
      m_intr = low;
      if (cs && wr && adr == 2'd1) m_mask = dout[7:0];
      if (cs && wr && adr == 2'd2) m_mode = dout[7:0];
      m_pend = npend;
      m_hist.push_front(int_l);
      void'(m_hist.pop_back());
      m_prev = m_s;
      m_s = m_hist[SS-1];
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
      chk("intr", {8'h00, intr}, {8'h00, m_intr});
      chk("datain", dat_in, m_dat);
   endtask

   task automatic idle_n(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
      cs = 1'b1; wr = 1'b1; adr = a; dout = d;
      tick();
      cs = 1'b0; wr = 1'b0; dout = 16'h0000;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
      cs = 1'b1; wr = 1'b0; adr = a;
      tick();
      cs = 1'b0;
      d = dat_in;
   endtask

   logic [15:0] rd;

   initial begin
      n_cmp = 0; n_err = 0;
      rst = 1'b1; int_l = 8'h10; cs = 1'b0; wr = 1'b0; adr = 2'd0; dout = 16'h0000;
      model_reset();
      #2;
      chk("reset_intr", {8'h00, intr}, 16'h0000);
      chk("reset_datain", dat_in, 16'h0000);
      idle_n(2);
      rst = 1'b0;

      // A line already high at reset release is seen as one rising edge.
      idle_n(SS + 1);
      bus_read(2'd0, rd);  chk("rel_edge_pend", rd, 16'h0010);
      int_l = 8'h00;
      bus_read(2'd2, rd);  chk("reset_mode", rd, 16'h00FF);
      bus_read(2'd1, rd);  chk("reset_mask", rd, 16'h0000);
      bus_write(2'd0, 16'hFFFF);
      idle_n(SS + 2);

      // Edge latency on INT[2].
      bus_write(2'd1, 16'h0004);
      int_l = 8'h04;
      idle_n(SS + 1);
      chk("lat_before", {8'h00, intr}, 16'h0000);
      tick();
      chk("lat_at", {8'h00, intr}, 16'h0004);
      int_l = 8'h00;
      idle_n(5);
      chk("lat_hold", {8'h00, intr}, 16'h0004);
      bus_read(2'd0, rd);  chk("lat_pend", rd, 16'h0004);
      bus_write(2'd0, 16'h0004);
      idle_n(2);

      // Priority and masking with INT[1] and INT[5].
      bus_write(2'd1, 16'h0020);
      int_l = 8'h22; tick(); int_l = 8'h00;
      idle_n(SS + 3);
      chk("prio_m20", {8'h00, intr}, 16'h0020);
      bus_read(2'd3, rd);  chk("prio_vec5", rd, 16'h8005);
      bus_write(2'd1, 16'h0022);
      tick();
      chk("prio_m22", {8'h00, intr}, 16'h0002);
      bus_read(2'd3, rd);  chk("prio_vec1", rd, 16'h8001);
      bus_write(2'd0, 16'h00FF);
      idle_n(2);
      chk("prio_clr", {8'h00, intr}, 16'h0000);

      // Clear colliding with a new INT[3] edge: set wins.
      bus_write(2'd1, 16'h0008);
      int_l = 8'h08; tick(); int_l = 8'h00;
      idle_n(SS + 3);
      chk("col_pre", {8'h00, intr}, 16'h0008);
      int_l = 8'h08;
      idle_n(SS);
      bus_write(2'd0, 16'h0008);
      int_l = 8'h00;
      bus_read(2'd0, rd);  chk("col_pend", rd, 16'h0008);
      bus_write(2'd0, 16'h0008);
      tick();
      chk("col_quiet", {8'h00, intr}, 16'h0000);
      bus_read(2'd0, rd);  chk("col_pend0", rd, 16'h0000);

      // Level mode on INT[0].
      bus_write(2'd2, 16'h00FE);
      bus_write(2'd1, 16'h0001);
      int_l = 8'h01;
      idle_n(10);
      chk("lvl_high", {8'h00, intr}, 16'h0001);
      bus_write(2'd0, 16'h0001);
      bus_read(2'd0, rd);  chk("lvl_noclr", rd, 16'h0001);
      int_l = 8'h00;
      idle_n(SS + 1);
      chk("lvl_fall_pre", {8'h00, intr}, 16'h0001);
      tick();
      chk("lvl_fall", {8'h00, intr}, 16'h0000);
      bus_read(2'd0, rd);  chk("lvl_pend0", rd, 16'h0000);

      // Asynchronous reset between edges with everything pending.
      bus_write(2'd2, 16'h00FF);
      int_l = 8'hFF; tick(); int_l = 8'h00;
      idle_n(SS + 2);
      bus_write(2'd1, 16'h00FF);
      bus_read(2'd1, rd);  chk("rst_pre_mask", rd, 16'h00FF);
      chk("rst_pre_intr", {8'h00, intr}, 16'h0001);
      cs = 1'b1; wr = 1'b1; adr = 2'd1; dout = 16'h0055;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_async_intr", {8'h00, intr}, 16'h0000);
      chk("rst_async_dat", dat_in, 16'h0000);
      tick();
      cs = 1'b0; wr = 1'b0; dout = 16'h0000;
      rst = 1'b0;
      bus_read(2'd2, rd);  chk("rst_mode", rd, 16'h00FF);
      bus_read(2'd1, rd);  chk("rst_mask", rd, 16'h0000);
      bus_read(2'd0, rd);  chk("rst_pend", rd, 16'h0000);

      // Randomized traffic; the per-edge model comparison carries the checking.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3) == 0) int_l[$urandom_range(7)] = ~int_l[$urandom_range(7)];
         case ($urandom_range(5))
            0, 1: begin cs = 1'b0; wr = 1'b0; end
            2, 3: begin cs = 1'b1; wr = 1'b0; adr = 2'($urandom_range(3)); end
            4:    begin cs = 1'b1; wr = 1'b1; adr = 2'($urandom_range(3)); dout = 16'($urandom); end
            default: begin cs = 1'b0; wr = 1'b1; dout = 16'($urandom); end
         endcase
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, legal 2..3: flip-flop stages on each INT line.
REQ-002 SHALL have port clk  input  1: single clock, the divided system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port INT  input  8: raw external interrupt lines, asynchronous to clk.
REQ-005 SHALL have port CS  input  1: chip select from the address decoder.
REQ-006 SHALL have port write  input  1: bus write strobe, qualified by CS.
REQ-007 SHALL have port adresse  input  2: register index.
REQ-008 SHALL have port DATAout  input  16: CPU write data.
REQ-009 SHALL have port DATAin  output  16: registered read data to the CPU bus mux.
REQ-010 SHALL have port Interrupts  output  8: one-hot request vector to the CPU interrupt input.

Function
REQ-011 SHALL synchronise each INT bit through SYNC_STAGES flops; sync output = s[i].
REQ-012 SHALL hold prev[i] = s[i] delayed one clk; rising edge detected when s[i]=1 and prev[i]=0.
REQ-013 SHALL keep 8-bit registers PEND, MASK (1 = enabled) and MODE (1 = rising-edge, 0 = level).
REQ-014 SHALL, edge mode: set PEND[i] on detected edge; hold until cleared by write-1-to-clear.
REQ-015 SHALL, level mode: load PEND[i] from s[i] every clk; write-1-to-clear has no effect.
REQ-016 SHALL, edge mode: give set priority over clear when both occur on the same edge (bit stays 1).
REQ-017 SHALL latch PEND regardless of MASK; masking affects only Interrupts and VECTOR.
REQ-018 SHALL define ACT = PEND & MASK; winner = lowest set index of ACT.
REQ-019 SHALL register Interrupts each clk as one-hot of winner, 8'h00 when ACT = 0.
REQ-020 SHALL give edge-to-Interrupts latency SYNC_STAGES+2 clk: INT rise set up before edge 1 gives Interrupts high after edge SYNC_STAGES+2, winner bit unmasked and no higher-priority bit active.
REQ-021 SHALL decode registers by adresse: 0 PEND, 1 MASK, 2 MODE, 3 VECTOR.
  - PEND: read; write-1-to-clear on DATAout[7:0].
  - MASK: read/write.
  - MODE: read/write.
  - VECTOR: read-only; bit15 = |ACT, bits[2:0] = winner index, 0 when ACT = 0, other bits 0.
REQ-022 SHALL perform a register write on an edge with CS=1 and write=1; DATAout[15:8] ignored.
REQ-023 SHALL ignore writes to VECTOR.
REQ-024 SHALL, when CS=1 and write=0, load DATAin on that edge; DATAin[15:8] = 0 except VECTOR bit15.
  - Read data is available one clk after the address (one-cycle read latency).
REQ-025 SHALL hold DATAin unchanged when CS=0 or write=1.
REQ-026 SHALL reflect a MASK/PEND write in Interrupts on the following edge (one-clk latency).
REQ-027 SHALL, on a MODE write, retain PEND; level-mode bits are then overwritten from s[] on the next edge.
REQ-028 SHALL NOT generate a second PEND set for one INT pulse.
  - A pulse held high for many clks sets PEND once.
  - Re-assertion requires s[i] to return to 0.

Reset
REQ-029 SHALL on rst=1 immediately force: sync flops 0, prev 0, PEND 8'h00, MASK 8'h00, MODE 8'hFF, Interrupts 8'h00, DATAin 16'h0000.
REQ-030 SHALL, on rst deassert with an INT line already high, detect a rising edge for that line once it propagates (prev was 0).
REQ-031 SHALL, on rst asserted mid-transaction, abandon any write and leave registers at reset values.

Verification
REQ-032 SHALL check edge latency.
  - Stimulus: MASK=8'h04; INT[2] 0->1 held.
  - Response: Interrupts=8'h04 exactly SYNC_STAGES+2 clks later; PEND=8'h04; stays after INT falls.
REQ-033 SHALL check priority and masking.
  - Stimulus: INT[1] and INT[5] pulse; MASK=8'h20.
  - Response: Interrupts=8'h20, VECTOR reads 16'h8005.
  - Then write MASK=8'h22: Interrupts=8'h02 next clk, VECTOR 16'h8001.
REQ-034 SHALL check clear-versus-set collision.
  - Stimulus: PEND[3]=1; write PEND with 8'h08 on the same edge a new INT[3] edge is detected.
  - Response: PEND[3] remains 1.
  - Clear on a quiet cycle -> PEND=0, Interrupts=8'h00 next clk.
REQ-035 SHALL check level mode.
  - Stimulus: MODE=8'hFE, MASK=8'h01; INT[0] high 10 clks, then low.
  - Response: PEND[0] tracks s[0] with one-clk lag.
  - Write-1-to-clear ignored while high; Interrupts[0] drops SYNC_STAGES+2 clks after INT[0] falls.
REQ-036 SHALL check reset mid-operation.
  - Stimulus: PEND=8'hFF, MASK=8'hFF; assert rst asynchronously between edges.
  - Response: Interrupts=8'h00 and DATAin=16'h0000 before the next edge.
  - After release, MODE reads 16'h00FF.
